// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream packet FIFO slice.
package axis_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    ACCEPT  = 1'b0,
    DISCARD = 1'b1
  } fifo_state_e;

endpackage

// File: rtl/simple_dual_port_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered,
// enable-gated output that holds its value while the enable is low.
module simple_dual_port_ram #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]     wr_data_i,
  input  logic                 rd_en_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [WIDTH-1:0]     rd_data_o
);

  logic [WIDTH-1:0] mem_q [0:(1<<ADDR_BITS)-1];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_packet_fifo.sv
// AXI-Stream FIFO with optional store-and-forward packet commit, error-packet
// dropping and oversize-packet discard.
module axis_packet_fifo
  import axis_pkg::*;
#(
  parameter int unsigned AXIS_BYTES     = 1,
  parameter int unsigned AXIS_USER_BITS = 1,
  parameter int unsigned LOG2_DEPTH     = 8,
  parameter int unsigned PACKET_MODE    = 1,
  parameter int unsigned DROP_ON_ERR    = 1
) (
  input  logic                          clk,
  input  logic                          sresetn,
  output logic                          axis_i_tready,
  input  logic                          axis_i_tvalid,
  input  logic                          axis_i_tlast,
  input  logic [BYTE_W*AXIS_BYTES-1:0]  axis_i_tdata,
  input  logic [AXIS_USER_BITS-1:0]     axis_i_tuser,
  input  logic                          axis_o_tready,
  output logic                          axis_o_tvalid,
  output logic                          axis_o_tlast,
  output logic [BYTE_W*AXIS_BYTES-1:0]  axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0]     axis_o_tuser,
  output logic [LOG2_DEPTH:0]           level_o,
  output logic [LOG2_DEPTH:0]           pkt_count_o,
  output logic                          drop_o
);

  localparam int unsigned DW = BYTE_W * AXIS_BYTES;
  localparam int unsigned WW = 1 + DW + AXIS_USER_BITS;
  localparam int unsigned PW = LOG2_DEPTH + 1;

  fifo_state_e   state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] level_q, level_d;
  logic [PW-1:0] pkt_count_q, pkt_count_d;
  logic          tvalid_q, tvalid_d;
  logic          drop_q, drop_d;

  logic          full;
  logic          in_progress;
  logic          overflow;
  logic          accept;
  logic          err_drop;
  logic          wr_en;
  logic          rd_en;
  logic          commit_inc;
  logic          out_dec;
  logic [WW-1:0] wr_word;
  logic [WW-1:0] rd_word;

  assign full = (wr_ptr_q[LOG2_DEPTH-1:0] == rd_ptr_q[LOG2_DEPTH-1:0]) &&
                (wr_ptr_q[LOG2_DEPTH] != rd_ptr_q[LOG2_DEPTH]);
  assign in_progress = (wr_ptr_q != commit_ptr_q);

  // A full memory holding only an uncommitted packet can never drain, so the
  // packet is abandoned; tready stays high so the source is not stalled.
  assign overflow = (PACKET_MODE != 0) && (state_q == ACCEPT) && full &&
                    in_progress && (rd_ptr_q == commit_ptr_q);

  assign axis_i_tready = (state_q == DISCARD) || !full || overflow;
  assign accept        = axis_i_tvalid && axis_i_tready;
  assign err_drop      = (PACKET_MODE != 0) && (DROP_ON_ERR != 0) &&
                         axis_i_tlast && axis_i_tuser[0];

  assign rd_en   = (rd_ptr_q != commit_ptr_q) && (!tvalid_q || axis_o_tready);
  assign out_dec = tvalid_q && axis_o_tready && axis_o_tlast;
  assign wr_word = {axis_i_tlast, axis_i_tdata, axis_i_tuser};

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    tvalid_d     = tvalid_q;
    drop_d       = 1'b0;
    wr_en        = 1'b0;
    commit_inc   = 1'b0;

    case (state_q)
      DISCARD: begin
        if (accept && axis_i_tlast) begin
          state_d = ACCEPT;
        end
      end
      default: begin
        if (overflow) begin
          wr_ptr_d = commit_ptr_q;
          drop_d   = 1'b1;
          if (!(accept && axis_i_tlast)) begin
            state_d = DISCARD;
          end
        end else if (accept) begin
          if (err_drop) begin
            wr_ptr_d = commit_ptr_q;
            drop_d   = 1'b1;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if ((PACKET_MODE == 0) || axis_i_tlast) begin
              commit_ptr_d = wr_ptr_q + PW'(1);
            end
            commit_inc = axis_i_tlast;
          end
        end
      end
    endcase

    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      tvalid_d = 1'b1;
    end else if (axis_o_tready) begin
      tvalid_d = 1'b0;
    end

    pkt_count_d = pkt_count_q + {{LOG2_DEPTH{1'b0}}, commit_inc}
                              - {{LOG2_DEPTH{1'b0}}, out_dec};
    level_d     = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state_q      <= ACCEPT;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      pkt_count_q  <= '0;
      tvalid_q     <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      pkt_count_q  <= pkt_count_d;
      tvalid_q     <= tvalid_d;
      drop_q       <= drop_d;
    end
  end

  // The RAM read register doubles as the output register; it only loads on rd_en.
  simple_dual_port_ram #(
    .WIDTH     (WW),
    .ADDR_BITS (LOG2_DEPTH)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q[LOG2_DEPTH-1:0]),
    .wr_data_i (wr_word),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_ptr_q[LOG2_DEPTH-1:0]),
    .rd_data_o (rd_word)
  );

  assign {axis_o_tlast, axis_o_tdata, axis_o_tuser} = rd_word;
  assign axis_o_tvalid = tvalid_q;
  assign level_o       = level_q;
  assign pkt_count_o   = pkt_count_q;
  assign drop_o        = drop_q;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Bench for axis_packet_fifo: directed packet scenarios on three parameter
// sets plus a long randomized run against a queue-based reference.
module tb_axis_packet_fifo;

  logic clk = 1'b0;
  logic sresetn;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // A: defaults (depth 256, store-and-forward, drop on error)
  logic a_itready, a_itvalid, a_itlast, a_otready, a_otvalid, a_otlast, a_drop;
  logic [7:0] a_itdata, a_otdata;
  logic [0:0] a_ituser, a_otuser;
  logic [8:0] a_level, a_pkt;
  // B: depth 4, store-and-forward
  logic b_itready, b_itvalid, b_itlast, b_otready, b_otvalid, b_otlast, b_drop;
  logic [7:0] b_itdata, b_otdata;
  logic [0:0] b_ituser, b_otuser;
  logic [2:0] b_level, b_pkt;
  // C: depth 4, cut-through
  logic c_itready, c_itvalid, c_itlast, c_otready, c_otvalid, c_otlast, c_drop;
  logic [7:0] c_itdata, c_otdata;
  logic [0:0] c_ituser, c_otuser;
  logic [2:0] c_level, c_pkt;

  axis_packet_fifo #(.AXIS_BYTES(1), .AXIS_USER_BITS(1), .LOG2_DEPTH(8),
                     .PACKET_MODE(1), .DROP_ON_ERR(1)) dut_a (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tready(a_itready), .axis_i_tvalid(a_itvalid), .axis_i_tlast(a_itlast),
    .axis_i_tdata(a_itdata), .axis_i_tuser(a_ituser),
    .axis_o_tready(a_otready), .axis_o_tvalid(a_otvalid), .axis_o_tlast(a_otlast),
    .axis_o_tdata(a_otdata), .axis_o_tuser(a_otuser),
    .level_o(a_level), .pkt_count_o(a_pkt), .drop_o(a_drop));

  axis_packet_fifo #(.AXIS_BYTES(1), .AXIS_USER_BITS(1), .LOG2_DEPTH(2),
                     .PACKET_MODE(1), .DROP_ON_ERR(1)) dut_b (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tready(b_itready), .axis_i_tvalid(b_itvalid), .axis_i_tlast(b_itlast),
    .axis_i_tdata(b_itdata), .axis_i_tuser(b_ituser),
    .axis_o_tready(b_otready), .axis_o_tvalid(b_otvalid), .axis_o_tlast(b_otlast),
    .axis_o_tdata(b_otdata), .axis_o_tuser(b_otuser),
    .level_o(b_level), .pkt_count_o(b_pkt), .drop_o(b_drop));

  axis_packet_fifo #(.AXIS_BYTES(1), .AXIS_USER_BITS(1), .LOG2_DEPTH(2),
                     .PACKET_MODE(0), .DROP_ON_ERR(1)) dut_c (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tready(c_itready), .axis_i_tvalid(c_itvalid), .axis_i_tlast(c_itlast),
    .axis_i_tdata(c_itdata), .axis_i_tuser(c_ituser),
    .axis_o_tready(c_otready), .axis_o_tvalid(c_otvalid), .axis_o_tlast(c_otlast),
    .axis_o_tdata(c_otdata), .axis_o_tuser(c_otuser),
    .level_o(c_level), .pkt_count_o(c_pkt), .drop_o(c_drop));

  // Output/drop recorders; inputs change on negedge, so handshakes are stable here.
  logic [8:0] a_outq[$];
  logic [8:0] b_outq[$];
  logic [8:0] c_outq[$];
  int a_drops = 0;
  int b_drops = 0;

  always begin
    @(negedge clk);
    #2;
    if (a_otvalid && a_otready) a_outq.push_back({a_otlast, a_otdata});
    if (b_otvalid && b_otready) b_outq.push_back({b_otlast, b_otdata});
    if (c_otvalid && c_otready) c_outq.push_back({c_otlast, c_otdata});
    if (a_drop) a_drops++;
    if (b_drop) b_drops++;
  end

  // Present one beat to DUT `which` (0=A,1=B,2=C) and return at the negedge after it is taken.
  task automatic send(input int which, input logic [7:0] d, input logic l, input logic u);
    logic rdy;
    for (int n = 0; n < 100; n++) begin
      case (which)
        0: begin a_itvalid = 1'b1; a_itdata = d; a_itlast = l; a_ituser = u; rdy = a_itready; end
        1: begin b_itvalid = 1'b1; b_itdata = d; b_itlast = l; b_ituser = u; rdy = b_itready; end
        default: begin c_itvalid = 1'b1; c_itdata = d; c_itlast = l; c_ituser = u; rdy = c_itready; end
      endcase
      @(negedge clk);
      if (rdy) return;
    end
    failures++;
    $display("FAIL send_timeout dut=%0d data=%02h not accepted within 100 cycles", which, d);
  endtask

  task automatic test_reset();
    sresetn = 1'b0;
    a_itvalid = 0; a_itlast = 0; a_itdata = 0; a_ituser = 0; a_otready = 0;
    b_itvalid = 0; b_itlast = 0; b_itdata = 0; b_ituser = 0; b_otready = 0;
    c_itvalid = 0; c_itlast = 0; c_itdata = 0; c_ituser = 0; c_otready = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_otvalid, a_level, a_pkt, a_drop} !== '0) begin
      failures++;
      $display("FAIL reset_a tvalid=%b level=%0d pkt=%0d drop=%b required all 0", a_otvalid, a_level, a_pkt, a_drop);
    end
    checks++;
    if ({b_otvalid, b_level, b_pkt, b_drop, c_otvalid, c_level, c_pkt, c_drop} !== '0) begin
      failures++;
      $display("FAIL reset_bc b: %b %0d %0d %b c: %b %0d %0d %b required all 0",
               b_otvalid, b_level, b_pkt, b_drop, c_otvalid, c_level, c_pkt, c_drop);
    end
    sresetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_itready, b_itready, c_itready} !== 3'b111) begin
      failures++;
      $display("FAIL reset_tready got=%b%b%b required 111", a_itready, b_itready, c_itready);
    end
  endtask

  task automatic test_store_forward();
    logic [8:0] exp_w;
    a_otready = 1'b1;
    a_outq.delete();
    for (int i = 0; i < 4; i++) begin
      send(0, 8'(i + 1), (i == 3), 1'b0);
      checks++;
      if (a_otvalid !== 1'b0) begin
        failures++;
        $display("FAIL sf_early_valid beat=%0d tvalid=%b required 0", i + 1, a_otvalid);
      end
    end
    a_itvalid = 1'b0;
    checks++;
    if (a_pkt !== 9'd1) begin
      failures++;
      $display("FAIL sf_pkt_commit got=%0d required 1", a_pkt);
    end
    @(negedge clk);
    checks++;
    if (a_otvalid !== 1'b1 || a_otdata !== 8'h01) begin
      failures++;
      $display("FAIL sf_first_out tvalid=%b data=%02h required 1/01", a_otvalid, a_otdata);
    end
    for (int n = 0; n < 20 && a_outq.size() < 4; n++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (a_outq.size() != 4) begin
      failures++;
      $display("FAIL sf_count got=%0d required 4", a_outq.size());
    end
    for (int i = 0; i < 4 && i < a_outq.size(); i++) begin
      exp_w = {(i == 3), 8'(i + 1)};
      checks++;
      if (a_outq[i] !== exp_w) begin
        failures++;
        $display("FAIL sf_data idx=%0d got=%03h required %03h", i, a_outq[i], exp_w);
      end
    end
    checks++;
    if (a_pkt !== 9'd0 || a_otvalid !== 1'b0) begin
      failures++;
      $display("FAIL sf_drained pkt=%0d tvalid=%b required 0/0", a_pkt, a_otvalid);
    end
  endtask

  task automatic test_error_drop();
    int d0;
    d0 = a_drops;
    a_otready = 1'b1;
    a_outq.delete();
    send(0, 8'h10, 1'b0, 1'b0);
    send(0, 8'h11, 1'b0, 1'b0);
    send(0, 8'h12, 1'b1, 1'b1);
    checks++;
    if (a_drop !== 1'b1) begin
      failures++;
      $display("FAIL err_drop_pulse got=%b required 1", a_drop);
    end
    send(0, 8'hA0, 1'b0, 1'b0);
    send(0, 8'hA1, 1'b1, 1'b0);
    a_itvalid = 1'b0;
    for (int n = 0; n < 20 && a_outq.size() < 2; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (a_outq.size() != 2) begin
      failures++;
      $display("FAIL err_count got=%0d required 2", a_outq.size());
    end else begin
      checks++;
      if (a_outq[0] !== 9'h0A0 || a_outq[1] !== 9'h1A1) begin
        failures++;
        $display("FAIL err_data got=%03h,%03h required 0a0,1a1", a_outq[0], a_outq[1]);
      end
    end
    checks++;
    if (a_drops - d0 != 1) begin
      failures++;
      $display("FAIL err_drop_count got=%0d required 1", a_drops - d0);
    end
    checks++;
    if (a_level !== 9'd0 || a_pkt !== 9'd0) begin
      failures++;
      $display("FAIL err_level level=%0d pkt=%0d required 0/0", a_level, a_pkt);
    end
  endtask

  task automatic test_overflow();
    int d0;
    d0 = b_drops;
    b_otready = 1'b1;
    b_outq.delete();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (b_itready !== 1'b1) begin
        failures++;
        $display("FAIL ovf_tready beat=%0d got=%b required 1", i + 1, b_itready);
      end
      send(1, 8'(8'h20 + i), (i == 5), 1'b0);
      if (i == 4) begin
        checks++;
        if (b_drop !== 1'b1) begin
          failures++;
          $display("FAIL ovf_drop_at_5 got=%b required 1", b_drop);
        end
      end
    end
    b_itvalid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (b_outq.size() != 0) begin
      failures++;
      $display("FAIL ovf_leak got=%0d beats required 0", b_outq.size());
    end
    send(1, 8'h30, 1'b0, 1'b0);
    send(1, 8'h31, 1'b1, 1'b0);
    b_itvalid = 1'b0;
    for (int n = 0; n < 20 && b_outq.size() < 2; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (b_outq.size() != 2) begin
      failures++;
      $display("FAIL ovf_next_count got=%0d required 2", b_outq.size());
    end else begin
      checks++;
      if (b_outq[0] !== 9'h030 || b_outq[1] !== 9'h131) begin
        failures++;
        $display("FAIL ovf_next_data got=%03h,%03h required 030,131", b_outq[0], b_outq[1]);
      end
    end
    checks++;
    if (b_drops - d0 != 1) begin
      failures++;
      $display("FAIL ovf_drop_count got=%0d required 1", b_drops - d0);
    end
  endtask

  task automatic test_cut_through();
    int idx;
    logic rdy;
    logic [8:0] exp_w;
    c_otready = 1'b0;
    c_outq.delete();
    idx = 0;
    c_itvalid = 1'b1; c_itdata = 8'h40; c_itlast = 1'b0; c_ituser = 1'b0;
    for (int n = 0; n < 12; n++) begin
      rdy = c_itready;
      @(negedge clk);
      if (rdy && c_itvalid) begin
        idx++;
        if (idx < 6) begin c_itdata = 8'(8'h40 + idx); c_itlast = (idx == 5); end
        else c_itvalid = 1'b0;
      end
    end
    checks++;
    if (idx != 5 || c_itready !== 1'b0) begin
      failures++;
      $display("FAIL ct_backpressure accepted=%0d tready=%b required 5/0", idx, c_itready);
    end
    checks++;
    if (c_level !== 3'd4) begin
      failures++;
      $display("FAIL ct_level got=%0d required 4", c_level);
    end
    checks++;
    if (c_otvalid !== 1'b1 || c_otdata !== 8'h40) begin
      failures++;
      $display("FAIL ct_outreg tvalid=%b data=%02h required 1/40", c_otvalid, c_otdata);
    end
    c_otready = 1'b1;
    for (int n = 0; n < 40 && c_outq.size() < 6; n++) begin
      rdy = c_itready;
      @(negedge clk);
      if (rdy && c_itvalid) begin
        idx++;
        if (idx < 6) begin c_itdata = 8'(8'h40 + idx); c_itlast = (idx == 5); end
        else c_itvalid = 1'b0;
      end
    end
    c_itvalid = 1'b0;
    checks++;
    if (c_outq.size() != 6) begin
      failures++;
      $display("FAIL ct_count got=%0d required 6", c_outq.size());
    end
    for (int i = 0; i < 6 && i < c_outq.size(); i++) begin
      exp_w = {(i == 5), 8'(8'h40 + i)};
      checks++;
      if (c_outq[i] !== exp_w) begin
        failures++;
        $display("FAIL ct_data idx=%0d got=%03h required %03h", i, c_outq[i], exp_w);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    a_otready = 1'b0;
    send(0, 8'h70, 1'b1, 1'b0);
    send(0, 8'h60, 1'b0, 1'b0);
    send(0, 8'h61, 1'b0, 1'b0);
    a_itvalid = 1'b0;
    checks++;
    if (a_otvalid !== 1'b1 || a_level !== 9'd2) begin
      failures++;
      $display("FAIL rst_pre tvalid=%b level=%0d required 1/2", a_otvalid, a_level);
    end
    sresetn = 1'b0;
    @(negedge clk);
    checks++;
    if (a_otvalid !== 1'b0 || a_level !== 9'd0 || a_pkt !== 9'd0) begin
      failures++;
      $display("FAIL rst_mid tvalid=%b level=%0d pkt=%0d required 0/0/0", a_otvalid, a_level, a_pkt);
    end
    sresetn = 1'b1;
    a_otready = 1'b1;
    a_outq.delete();
    send(0, 8'h55, 1'b1, 1'b0);
    a_itvalid = 1'b0;
    for (int n = 0; n < 20 && a_outq.size() < 1; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (a_outq.size() != 1) begin
      failures++;
      $display("FAIL rst_after_count got=%0d required 1", a_outq.size());
    end else begin
      checks++;
      if (a_outq[0] !== 9'h155) begin
        failures++;
        $display("FAIL rst_after_data got=%03h required 155", a_outq[0]);
      end
    end
  endtask

  task automatic test_random();
    logic [8:0] q[$];
    logic [8:0] exp_w, prev_w;
    logic prev_stall, in_hs, out_hs, pend;
    int sent, rcvd, tl_in, tl_out, cur_len, cyc;
    sent = 0; rcvd = 0; tl_in = 0; tl_out = 0; cur_len = 0; cyc = 0;
    pend = 1'b0; prev_stall = 1'b0; prev_w = '0;
    a_itvalid = 1'b0; a_otready = 1'b0; a_ituser = 1'b0;
    @(negedge clk);
    while (rcvd < 10000 && cyc < 60000) begin
      checks++;
      if (a_pkt !== 9'(tl_in - tl_out)) begin
        failures++;
        $display("FAIL rnd_pkt_count cyc=%0d got=%0d required %0d", cyc, a_pkt, tl_in - tl_out);
      end
      if (prev_stall) begin
        checks++;
        if (a_otvalid !== 1'b1 || {a_otlast, a_otdata} !== prev_w) begin
          failures++;
          $display("FAIL rnd_hold cyc=%0d got=%b/%03h required 1/%03h", cyc, a_otvalid, {a_otlast, a_otdata}, prev_w);
        end
      end
      if (!pend) begin
        if (sent < 10000) begin
          a_itvalid = 1'($urandom_range(0, 1));
          a_itdata  = 8'($urandom);
          a_itlast  = (cur_len == 15) || (sent == 9999) || ($urandom_range(0, 4) == 0);
        end else begin
          a_itvalid = 1'b0;
        end
      end
      a_otready = 1'($urandom_range(0, 1));
      in_hs  = a_itvalid && a_itready;
      out_hs = a_otvalid && a_otready;
      pend   = a_itvalid && !a_itready;
      if (in_hs) begin
        q.push_back({a_itlast, a_itdata});
        sent++;
        if (a_itlast) begin tl_in++; cur_len = 0; end
        else cur_len++;
      end
      if (out_hs) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rnd_extra cyc=%0d got=%03h required no beat", cyc, {a_otlast, a_otdata});
        end else begin
          exp_w = q.pop_front();
          if ({a_otlast, a_otdata} !== exp_w) begin
            failures++;
            $display("FAIL rnd_data beat=%0d got=%03h required %03h", rcvd, {a_otlast, a_otdata}, exp_w);
          end
        end
        rcvd++;
        if (a_otlast) tl_out++;
      end
      prev_stall = a_otvalid && !a_otready;
      prev_w     = {a_otlast, a_otdata};
      @(negedge clk);
      cyc++;
    end
    a_itvalid = 1'b0;
    checks++;
    if (cyc >= 60000 || sent != 10000 || q.size() != 0) begin
      failures++;
      $display("FAIL rnd_complete cycles=%0d sent=%0d left=%0d required <60000/10000/0", cyc, sent, q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store_forward();
    test_error_drop();
    test_overflow();
    test_cut_through();
    test_reset_mid_packet();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_packet_fifo.md
AXIS_PACKET_FIFO -- requirements
Module: axis_packet_fifo

Interface
REQ-001 SHALL have parameter AXIS_BYTES, default 1, tdata width in bytes.
REQ-002 SHALL have parameter AXIS_USER_BITS, default 1, tuser width.
REQ-003 SHALL have parameter LOG2_DEPTH, default 8, storage depth 2**LOG2_DEPTH words.
REQ-004 SHALL have parameter PACKET_MODE, default 1; 0 = cut-through, 1 = store-and-forward.
REQ-005 SHALL have parameter DROP_ON_ERR, default 1; 1 = drop packet whose tlast beat has tuser[0]=1 (PACKET_MODE=1 only).
REQ-006 SHALL have ports: clk  in  1  clock; sresetn  in  1  reset, synchronous, active-low.
REQ-007 SHALL have ports: axis_i_tready out 1; axis_i_tvalid in 1; axis_i_tlast in 1; axis_i_tdata in 8*AXIS_BYTES; axis_i_tuser in AXIS_USER_BITS -- input stream.
REQ-008 SHALL have ports: axis_o_tready in 1; axis_o_tvalid out 1; axis_o_tlast out 1; axis_o_tdata out 8*AXIS_BYTES; axis_o_tuser out AXIS_USER_BITS -- output stream.
REQ-009 SHALL have ports: level_o out LOG2_DEPTH+1 words in memory; pkt_count_o out LOG2_DEPTH+1 committed packets not yet fully read; drop_o out 1 one-cycle pulse per dropped packet.

Function
REQ-010 SHALL store {tlast, tdata, tuser} per word; pointers LOG2_DEPTH+1 bits, wrap modulo 2**(LOG2_DEPTH+1).
REQ-011 SHALL accept a word on edge where axis_i_tvalid && axis_i_tready.
REQ-012 SHALL drive axis_i_tready=0 only when memory full (address bits equal, MSBs differ) and state is ACCEPT; in DISCARD tready=1.
REQ-013 SHALL maintain wr_ptr, commit_ptr, rd_ptr; PACKET_MODE=0: commit_ptr tracks wr_ptr every accept.
REQ-014 SHALL, PACKET_MODE=1, set commit_ptr to wr_ptr+1 on the accepted tlast beat (unless dropped).
REQ-015 SHALL register output: load output register from mem[rd_ptr] when rd_ptr!=commit_ptr and (!axis_o_tvalid || axis_o_tready); tvalid cleared on tready with no load.
REQ-016 SHALL give latency: word/commit on edge k -> axis_o_tvalid high after edge k+1 earliest.
REQ-017 SHALL hold output tdata/tuser/tlast stable while tvalid && !tready.
REQ-018 SHALL, on accepted tlast with tuser[0]=1 and DROP_ON_ERR=1 and PACKET_MODE=1, rewind wr_ptr to commit_ptr, not commit, pulse drop_o next cycle.
REQ-019 SHALL, PACKET_MODE=1, detect overflow when full, packet in progress and rd_ptr==commit_ptr: rewind wr_ptr to commit_ptr, pulse drop_o, enter DISCARD.
REQ-020 SHALL, in DISCARD, accept and discard beats; on accepted tlast return to ACCEPT; next beat starts a new packet.
REQ-021 SHALL, full with committed data ahead (rd_ptr!=commit_ptr), backpressure instead of dropping.
REQ-022 SHALL compute level_o = wr_ptr - rd_ptr (registered); pkt_count_o +1 per commit, -1 per tlast leaving on axis_o handshake; simultaneous inc/dec leaves it unchanged.
REQ-023 SHALL permit simultaneous write and read in one cycle, including at full (read frees slot next cycle, not same cycle).

Reset
REQ-024 SHALL, while sresetn=0 at clk edge, clear all pointers, pkt_count_o, level_o, drop_o, axis_o_tvalid, state=ACCEPT; memory contents undefined.
REQ-025 SHALL, on reset mid-packet, discard partial and stored packets; first beat after reset starts a new packet.

Structure
REQ-026 SHALL place state enum (ACCEPT, DISCARD) in shared package axis_pkg.
REQ-027 SHALL instantiate one sub-module, simple_dual_port_ram (one write, one registered read port), for storage.

Verification
REQ-028 SHALL cover: PACKET_MODE=1, 4-beat packet 0x01..0x04 written, axis_o_tready=1 -> no tvalid until 1 cycle after tlast accept, then 0x01..0x04, tlast on 0x04, pkt_count 1->0.
REQ-029 SHALL cover: DROP_ON_ERR=1, 3-beat packet with tuser[0]=1 on tlast, then good 2-beat packet 0xA0,0xA1 -> drop_o one pulse, output only 0xA0,0xA1.
REQ-030 SHALL cover: LOG2_DEPTH=2, PACKET_MODE=1, 6-beat packet into empty FIFO -> drop_o pulse at 5th beat, tready stays 1, nothing output; following 2-beat packet passes.
REQ-031 SHALL cover: PACKET_MODE=0, LOG2_DEPTH=2, 6 words with axis_o_tready=0 -> 4 accepted (plus 1 in output reg), tready=0, level_o=4; release tready -> all 5..6 in order, no loss.
REQ-032 SHALL cover: reset asserted after 2 beats of a packet -> tvalid=0, level_o=0, pkt_count_o=0 next cycle; new 1-beat packet 0x55 passes.
REQ-033 SHALL cover: random tvalid/tready 50% for 10000 beats, no errors -> output sequence equals input, pkt_count_o never exceeds stored packets.
